weight_pingpong_ctrl: RTL and testbench

//  Ping-pong address/bank controller for the weight memory unit. Fills one

---
 rtl/weight_pingpong_ctrl_pkg.sv | 25 ++
 rtl/wm_sweep_counter.sv | 89 ++++++++
 rtl/weight_pingpong_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_weight_pingpong_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/weight_pingpong_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// weight_pingpong_ctrl_pkg
//   Shared definitions for the weight ping-pong controller: write/read FSM
//   state encodings and the bank-index type used for the two-bank BRAM pair.
// -----------------------------------------------------------------------------
package weight_pingpong_ctrl_pkg;

    // Two banks, so a single bit selects one of them.
    localparam int BANK_W = 1;

    typedef logic [BANK_W-1:0] bank_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_WAIT = 2'd1,
        W_FILL = 2'd2
    } wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RUN  = 2'd2
    } rd_state_e;

endpackage : weight_pingpong_ctrl_pkg

// File: rtl/wm_sweep_counter.sv
// -----------------------------------------------------------------------------
// wm_sweep_counter
//   Address sweep counter with a repeat (pass) count. On load_i the last
//   address and last pass are captured and the counter restarts at 0/0.
//   Every step_i advances the address; at the last address it wraps to 0 and
//   the pass count advances, wrapping to 0 after the last pass, so the counter
//   is back at its start position once a full sweep completes.
//
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   clear_i      in   synchronous clear of address and pass count
//   load_i       in   capture addr_last_i / pass_last_i and restart at 0/0
//   step_i       in   advance by one address
//   addr_last_i  in   last address of the sweep
//   pass_last_i  in   number of passes minus 1
//   addr_o       out  current address (registered)
//   done_o       out  current position is the last address of the last pass
// -----------------------------------------------------------------------------
module wm_sweep_counter #(
    parameter int ADDR_W = 8,
    parameter int PASS_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [ADDR_W-1:0] addr_last_i,
    input  logic [PASS_W-1:0] pass_last_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              done_o
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] addr_last_q, addr_last_d;
    logic [PASS_W-1:0] pass_q, pass_d;
    logic [PASS_W-1:0] pass_last_q, pass_last_d;

    logic addr_at_last;
    logic pass_at_last;

    assign addr_at_last = (addr_q == addr_last_q);
    assign pass_at_last = (pass_q == pass_last_q);

    // NOTE: every variable driven here gets its hold value first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        addr_d      = addr_q;
        pass_d      = pass_q;
        addr_last_d = addr_last_q;
        pass_last_d = pass_last_q;
        if (clear_i) begin
            addr_d = '0;
            pass_d = '0;
        end else if (load_i) begin
            addr_d      = '0;
            pass_d      = '0;
            addr_last_d = addr_last_i;
            pass_last_d = pass_last_i;
        end else if (step_i) begin
            if (addr_at_last) begin
                addr_d = '0;
                pass_d = pass_at_last ? '0 : pass_q + 1'b1;
            end else begin
                addr_d = addr_q + 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q      <= '0;
            pass_q      <= '0;
            addr_last_q <= '0;
            pass_last_q <= '0;
        end else begin
            addr_q      <= addr_d;
            pass_q      <= pass_d;
            addr_last_q <= addr_last_d;
            pass_last_q <= pass_last_d;
        end
    end

    assign addr_o = addr_q;
    assign done_o = addr_at_last && pass_at_last;

endmodule : wm_sweep_counter

// File: rtl/weight_pingpong_ctrl.sv
// -----------------------------------------------------------------------------
// weight_pingpong_ctrl
//   Ping-pong bank controller for the weight memory. The write FSM fills one
//   bank from the loader stream while the read FSM sweeps the other bank for
//   the PE array, repeating the sweep cfg_reuse_last+1 times. bank_full tracks
//   which banks hold a complete tile; a writer waits for its bank to be
//   released and a reader waits for its bank to be filled.
//
//   clk, rst         clock / asynchronous active-high reset
//   flush            synchronous abort of both FSMs, clears bank_full
//   cfg_wr_last      last write address of a tile (sampled on load_start)
//   cfg_rd_last      last read address of a tile (sampled on compute_start)
//   cfg_reuse_last   read passes minus 1 (sampled on compute_start)
//   load_start       start filling the next write bank
//   wr_valid/ready   loader handshake; wr_en = wr_valid & wr_ready
//   wr_bank/addr_wr  BRAM write bank and address
//   load_done        1-cycle pulse after the last word of a tile
//   compute_start    start sweeping the next read bank
//   rd_en/addr_rd    registered BRAM read enable and address
//   rd_bank          bank being read
//   rd_last          final address of the final pass
//   compute_done     1-cycle pulse when the read bank is released
//   bank_full        per-bank valid-tile flags
//   busy             either FSM not idle
// -----------------------------------------------------------------------------
module weight_pingpong_ctrl
    import weight_pingpong_ctrl_pkg::*;
#(
    parameter int WR_ADDR_DEPTH = 10,
    parameter int RD_ADDR_DEPTH = 8,
    parameter int REUSE_W       = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [WR_ADDR_DEPTH-1:0] cfg_wr_last,
    input  logic [RD_ADDR_DEPTH-1:0] cfg_rd_last,
    input  logic [REUSE_W-1:0]       cfg_reuse_last,
    input  logic                     load_start,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    output logic                     wr_en,
    output logic                     wr_bank,
    output logic [WR_ADDR_DEPTH-1:0] addr_wr,
    output logic                     load_done,
    input  logic                     compute_start,
    output logic                     rd_en,
    output logic                     rd_bank,
    output logic [RD_ADDR_DEPTH-1:0] addr_rd,
    output logic                     rd_last,
    output logic                     compute_done,
    output logic [1:0]               bank_full,
    output logic                     busy
);

    wr_state_e  wr_state_q, wr_state_d;
    rd_state_e  rd_state_q, rd_state_d;
    bank_t      wr_ptr_q, wr_ptr_d;
    bank_t      rd_ptr_q, rd_ptr_d;
    logic [1:0] bank_full_q, bank_full_d;
    logic       load_done_q, load_done_d;
    logic       compute_done_q, compute_done_d;
    logic       rd_en_q, rd_en_d;

    logic wr_cnt_load, wr_cnt_step, wr_cnt_done;
    logic rd_cnt_load, rd_cnt_step, rd_cnt_done;
    logic bank_set, bank_clr;

    // Write addresses: a single pass per tile.
    wm_sweep_counter #(
        .ADDR_W (WR_ADDR_DEPTH),
        .PASS_W (1)
    ) u_wr_cnt (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (flush),
        .load_i      (wr_cnt_load),
        .step_i      (wr_cnt_step),
        .addr_last_i (cfg_wr_last),
        .pass_last_i (1'b0),
        .addr_o      (addr_wr),
        .done_o      (wr_cnt_done)
    );

    // Read addresses: cfg_reuse_last+1 passes over the tile.
    wm_sweep_counter #(
        .ADDR_W (RD_ADDR_DEPTH),
        .PASS_W (REUSE_W)
    ) u_rd_cnt (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (flush),
        .load_i      (rd_cnt_load),
        .step_i      (rd_cnt_step),
        .addr_last_i (cfg_rd_last),
        .pass_last_i (cfg_reuse_last),
        .addr_o      (addr_rd),
        .done_o      (rd_cnt_done)
    );

    assign wr_ready = (wr_state_q == W_FILL);
    assign wr_en    = wr_valid & wr_ready;

    // Write FSM
    always_comb begin
        wr_state_d  = wr_state_q;
        wr_ptr_d    = wr_ptr_q;
        wr_cnt_load = 1'b0;
        wr_cnt_step = 1'b0;
        bank_set    = 1'b0;
        load_done_d = 1'b0;
        unique case (wr_state_q)
            W_IDLE: begin
                if (load_start) begin
                    wr_cnt_load = 1'b1;
                    wr_state_d  = bank_full_q[wr_ptr_q] ? W_WAIT : W_FILL;
                end
            end
            W_WAIT: begin
                if (!bank_full_q[wr_ptr_q]) begin
                    wr_state_d = W_FILL;
                end
            end
            W_FILL: begin
                if (wr_en) begin
                    // The last word wraps the counter back to address 0.
                    wr_cnt_step = 1'b1;
                    if (wr_cnt_done) begin
                        bank_set    = 1'b1;
                        wr_ptr_d    = wr_ptr_q + bank_t'(1);
                        load_done_d = 1'b1;
                        wr_state_d  = W_IDLE;
                    end
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
        if (flush) begin
            wr_state_d  = W_IDLE;
            wr_ptr_d    = '0;
            load_done_d = 1'b0;
        end
    end

    // Read FSM. The first cycle in R_RUN only raises rd_en; from then on each
    // cycle with rd_en high consumes one address.
    always_comb begin
        rd_state_d     = rd_state_q;
        rd_ptr_d       = rd_ptr_q;
        rd_cnt_load    = 1'b0;
        rd_cnt_step    = 1'b0;
        bank_clr       = 1'b0;
        rd_en_d        = 1'b0;
        compute_done_d = 1'b0;
        unique case (rd_state_q)
            R_IDLE: begin
                if (compute_start) begin
                    rd_cnt_load = 1'b1;
                    rd_state_d  = bank_full_q[rd_ptr_q] ? R_RUN : R_WAIT;
                end
            end
            R_WAIT: begin
                if (bank_full_q[rd_ptr_q]) begin
                    rd_state_d = R_RUN;
                end
            end
            R_RUN: begin
                rd_cnt_step = rd_en_q;
                if (rd_en_q && rd_cnt_done) begin
                    bank_clr       = 1'b1;
                    rd_ptr_d       = rd_ptr_q + bank_t'(1);
                    compute_done_d = 1'b1;
                    rd_state_d     = R_IDLE;
                end else begin
                    rd_en_d = 1'b1;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
        if (flush) begin
            rd_state_d     = R_IDLE;
            rd_ptr_d       = '0;
            rd_en_d        = 1'b0;
            compute_done_d = 1'b0;
        end
    end

    // Writer and reader always point at different banks when both act in the
    // same cycle, so set and clear never collide.
    always_comb begin
        bank_full_d = bank_full_q;
        if (bank_set) bank_full_d[wr_ptr_q] = 1'b1;
        if (bank_clr) bank_full_d[rd_ptr_q] = 1'b0;
        if (flush)    bank_full_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state_q     <= W_IDLE;
            rd_state_q     <= R_IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            bank_full_q    <= '0;
            load_done_q    <= 1'b0;
            compute_done_q <= 1'b0;
            rd_en_q        <= 1'b0;
        end else begin
            wr_state_q     <= wr_state_d;
            rd_state_q     <= rd_state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            bank_full_q    <= bank_full_d;
            load_done_q    <= load_done_d;
            compute_done_q <= compute_done_d;
            rd_en_q        <= rd_en_d;
        end
    end

    assign wr_bank      = wr_ptr_q;
    assign rd_bank      = rd_ptr_q;
    assign load_done    = load_done_q;
    assign compute_done = compute_done_q;
    assign rd_en        = rd_en_q;
    assign rd_last      = rd_en_q & rd_cnt_done;
    assign bank_full    = bank_full_q;
    assign busy         = (wr_state_q != W_IDLE) || (rd_state_q != R_IDLE);

endmodule : weight_pingpong_ctrl

// File: tb/tb_weight_pingpong_ctrl.sv
// -----------------------------------------------------------------------------
// tb_weight_pingpong_ctrl
//   Tile-level reference model: each issued load pushes the word sequence it
//   must produce, each issued compute pushes its full read sequence; a monitor
//   on the falling edge pops and compares whenever wr_en / rd_en fire and
//   tracks which banks hold complete tiles.
// -----------------------------------------------------------------------------
module tb_weight_pingpong_ctrl;

    localparam int WA = 10;
    localparam int RA = 8;
    localparam int RW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [WA-1:0] cfg_wr_last;
    logic [RA-1:0] cfg_rd_last;
    logic [RW-1:0] cfg_reuse_last;
    logic          load_start;
    logic          wr_valid;
    logic          wr_ready;
    logic          wr_en;
    logic          wr_bank;
    logic [WA-1:0] addr_wr;
    logic          load_done;
    logic          compute_start;
    logic          rd_en;
    logic          rd_bank;
    logic [RA-1:0] addr_rd;
    logic          rd_last;
    logic          compute_done;
    logic [1:0]    bank_full;
    logic          busy;

    weight_pingpong_ctrl #(
        .WR_ADDR_DEPTH (WA),
        .RD_ADDR_DEPTH (RA),
        .REUSE_W       (RW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .cfg_wr_last    (cfg_wr_last),
        .cfg_rd_last    (cfg_rd_last),
        .cfg_reuse_last (cfg_reuse_last),
        .load_start     (load_start),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_en          (wr_en),
        .wr_bank        (wr_bank),
        .addr_wr        (addr_wr),
        .load_done      (load_done),
        .compute_start  (compute_start),
        .rd_en          (rd_en),
        .rd_bank        (rd_bank),
        .addr_rd        (addr_rd),
        .rd_last        (rd_last),
        .compute_done   (compute_done),
        .bank_full      (bank_full),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit bank;
        int addr;
        bit last;
    } exp_t;

    exp_t wq[$];
    exp_t rq[$];
    bit   model_full[2];
    int   wr_tiles = 0;
    int   rd_tiles = 0;
    int   errors   = 0;
    int   checks   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] all_outputs();
        return 32'({wr_ready, wr_en, wr_bank, addr_wr, load_done, rd_en, rd_bank,
                    addr_rd, rd_last, compute_done, bank_full, busy});
    endfunction

    // ---------------- monitor / scoreboard ----------------
    bit   ld_pend, ld_bank, cd_pend, cd_bank, rd_in_tile;
    exp_t we, re;

    always @(negedge clk) begin
        if (rst || flush) begin
            ld_pend = 0; cd_pend = 0; rd_in_tile = 0;
            model_full[0] = 0; model_full[1] = 0;
            wq.delete();
            rq.delete();
        end else begin
            if (ld_pend) begin
                check("load_done", 32'(load_done), 32'd1);
                model_full[ld_bank] = 1;
                ld_pend = 0;
            end else begin
                check("load_done_quiet", 32'(load_done), 32'd0);
            end
            if (cd_pend) begin
                check("compute_done", 32'(compute_done), 32'd1);
                check("rd_en_after_last", 32'(rd_en), 32'd0);
                model_full[cd_bank] = 0;
                cd_pend = 0;
            end else begin
                check("compute_done_quiet", 32'(compute_done), 32'd0);
                if (rd_in_tile) check("rd_en_no_gap", 32'(rd_en), 32'd1);
            end
            check("wr_en_handshake", 32'(wr_en), 32'(wr_valid & wr_ready));
            if (wr_en) begin
                if (wq.size() == 0) begin
                    check("wr_unexpected", 32'd1, 32'd0);
                end else begin
                    we = wq.pop_front();
                    check("addr_wr", 32'(addr_wr), 32'(we.addr));
                    check("wr_bank", 32'(wr_bank), 32'(we.bank));
                    if (we.last) begin
                        ld_pend = 1;
                        ld_bank = we.bank;
                    end
                end
            end
            if (rd_en) begin
                if (rq.size() == 0) begin
                    check("rd_unexpected", 32'd1, 32'd0);
                end else begin
                    re = rq.pop_front();
                    check("addr_rd", 32'(addr_rd), 32'(re.addr));
                    check("rd_bank", 32'(rd_bank), 32'(re.bank));
                    check("rd_last", 32'(rd_last), 32'(re.last));
                    rd_in_tile = !re.last;
                    if (re.last) begin
                        cd_pend = 1;
                        cd_bank = re.bank;
                    end
                end
            end else begin
                check("rd_last_quiet", 32'(rd_last), 32'd0);
            end
            check("bank_full", 32'(bank_full), 32'({model_full[1], model_full[0]}));
        end
    end

    // ---------------- stimulus ----------------
    task automatic load_tile(input int wl);
        bit b = wr_tiles[0];
        int n = 0;
        wr_tiles++;
        for (int a = 0; a <= wl; a++) wq.push_back('{b, a, a == wl});
        cfg_wr_last = WA'(wl);
        load_start  = 1'b1;
        wr_valid    = 1'($urandom);
        tick();
        load_start = 1'b0;
        while (!load_done && n < 2000) begin
            if (model_full[b]) check("wr_ready_wait", 32'(wr_ready), 32'd0);
            wr_valid    = ($urandom % 4) != 0;
            cfg_wr_last = WA'($urandom);          // must be ignored mid-tile
            load_start  = ($urandom % 8) == 0;    // must be ignored mid-tile
            tick();
            n++;
        end
        load_start = 1'b0;
        wr_valid   = 1'($urandom);                // no write may happen while idle
        check("load_timeout", 32'(n < 2000), 32'd1);
    endtask

    task automatic compute_tile(input int rl, input int ul);
        bit b = rd_tiles[0];
        bit full0;
        int n = 1;
        rd_tiles++;
        for (int p = 0; p <= ul; p++)
            for (int a = 0; a <= rl; a++)
                rq.push_back('{b, a, (p == ul) && (a == rl)});
        full0          = model_full[b];
        cfg_rd_last    = RA'(rl);
        cfg_reuse_last = RW'(ul);
        compute_start  = 1'b1;
        tick();
        compute_start = 1'b0;
        while (!compute_done && n < 4000) begin
            if (!model_full[b]) check("rd_en_wait", 32'(rd_en), 32'd0);
            if (full0 && n <= 2) check("first_rd_latency", 32'(rd_en), 32'(n == 2));
            cfg_rd_last    = RA'($urandom);
            cfg_reuse_last = RW'($urandom);
            compute_start  = ($urandom % 8) == 0;
            tick();
            n++;
        end
        compute_start = 1'b0;
        check("compute_timeout", 32'(n < 4000), 32'd1);
    endtask

    // Fill five words of a ten-word tile, then abort with flush or rst.
    task automatic abort_fill(input bit use_rst);
        bit b = wr_tiles[0];
        for (int a = 0; a < 5; a++) wq.push_back('{b, a, 1'b0});
        cfg_wr_last = WA'(9);
        load_start  = 1'b1;
        wr_valid    = 1'b0;
        tick();
        load_start = 1'b0;
        wr_valid   = 1'b1;
        repeat (5) tick();
        wr_valid = 1'b0;
        check("abort_addr_wr", 32'(addr_wr), 32'd5);
        check("abort_busy", 32'(busy), 32'd1);
        if (use_rst) begin
            rst = 1'b1;
            #2;
            check("rst_outputs", all_outputs(), 32'd0);
            tick();
            rst = 1'b0;
        end else begin
            flush = 1'b1;
            tick();
            flush = 1'b0;
            check("flush_outputs", all_outputs(), 32'd0);
        end
        wr_tiles = 0;
        rd_tiles = 0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; flush = 1'b0; load_start = 1'b0; wr_valid = 1'b0;
        compute_start = 1'b0; cfg_wr_last = '0; cfg_rd_last = '0; cfg_reuse_last = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", all_outputs(), 32'd0);
        rst = 1'b0;
        tick();

        // single tile: four words, then two passes of three reads
        load_tile(3);
        check("t1_bank_full", 32'(bank_full), 32'd1);
        compute_tile(2, 1);
        check("t2_bank_full", 32'(bank_full), 32'd0);

        // overlap: fill one bank while the other is swept
        load_tile(5);
        fork
            load_tile(6);
            compute_tile(3, 2);
        join
        check("t3_bank_full", 32'(bank_full), 32'd1);

        // both banks full: the next load waits for a read to release its bank
        load_tile(2);
        check("t4_both_full", 32'(bank_full), 32'd3);
        fork
            load_tile(3);
            begin repeat (6) tick(); compute_tile(1, 1); end
        join
        compute_tile(0, 0);
        compute_tile(4, 0);
        check("t4_drained", 32'(bank_full), 32'd0);

        // compute on an empty bank waits for the fill
        fork
            compute_tile(2, 2);
            begin repeat (6) tick(); load_tile(0); end
        join

        // randomized free-running producer / consumer
        fork
            begin
                for (int k = 0; k < 20; k++) begin
                    repeat ($urandom % 5) tick();
                    load_tile(int'($urandom_range(0, 9)));
                end
            end
            begin
                for (int k = 0; k < 20; k++) begin
                    repeat ($urandom % 8) tick();
                    compute_tile(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
                end
            end
        join

        // leave the pointers on bank 1, then abort mid-fill
        load_tile(1);
        compute_tile(1, 0);
        abort_fill(1'b0);
        load_tile(2);
        compute_tile(1, 1);
        abort_fill(1'b1);
        load_tile(0);
        compute_tile(0, 0);

        repeat (3) tick();
        check("wq_drained", 32'(wq.size()), 32'd0);
        check("rq_drained", 32'(rq.size()), 32'd0);
        check("final_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_weight_pingpong_ctrl
